risc5_mem_bridge: RTL and testbench
===================================

RISC5_MEM_BRIDGE -- requirements
Module: risc5_mem_bridge

Interface
REQ-001 SHALL have ports: clk in 1, CPU/system clock; rst in 1, synchronous reset, active-low.
REQ-002 SHALL have CPU-side inputs: adr in 24, byte address; rd in 1; wr in 1; ben in 1, byte access; outbus in 32, store data.
REQ-003 SHALL have CPU-side outputs: inbus out 32, load data; codebus out 32, instruction word; stallX out 1, external stall.
REQ-004 SHALL have memory-side ports: mem_req out 1; mem_we out 1; mem_be out 4; mem_addr out 22, word address; mem_wdata out 32; mem_ack in 1; mem_rdata in 32.
REQ-005 SHALL have port io_sel out 1, high when adr[23:6] is all ones.
REQ-006 SHALL have parameter IO_BASE, default 24'hFFFFC0, lowest I/O byte address.

Function
REQ-007 SHALL classify each cycle: data access = (rd|wr) & ~io_sel; fetch = ~rd & ~wr; I/O = (rd|wr) & io_sel, passed through with no memory request and no stall.
REQ-008 SHALL use FSM states IDLE, FETCH, LOAD, STORE.
REQ-009 IDLE: data load -> LOAD; data store -> STORE; fetch whose word address differs from fetch tag, or tag invalid -> FETCH; otherwise stay in IDLE.
REQ-010 SHALL hold mem_req high with mem_addr, mem_we, mem_be and mem_wdata stable from state entry until the cycle mem_ack is high, then return to IDLE.
REQ-011 mem_addr SHALL be adr[23:2] captured at state entry.
REQ-012 STORE mem_be SHALL be 4'b1111 for word stores and the one-hot of adr[1:0] for ben stores; mem_wdata = outbus; mem_we = 1.
REQ-013 LOAD and FETCH SHALL drive mem_be = 4'b1111 and mem_we = 0.
REQ-014 stallX SHALL be combinational: high whenever the FSM is not IDLE, and also in any IDLE cycle that leaves IDLE; it SHALL drop in the cycle after mem_ack.
REQ-015 On an ack in LOAD, mem_rdata SHALL be registered into inbus and held until the next load completes.
REQ-016 On an ack in FETCH, mem_rdata SHALL be registered into codebus, the fetch tag SHALL be set to mem_addr, and the tag SHALL be marked valid.
REQ-017 A fetch hit (tag valid and equal to adr[23:2]) SHALL cost zero stall cycles and leave codebus unchanged.
REQ-018 A store whose word address equals the fetch tag SHALL invalidate the tag.
REQ-019 mem_ack received while in IDLE SHALL be ignored.
REQ-020 Store-then-fetch SHALL issue the fetch only after the store ack; requests SHALL never overlap.

Reset
REQ-021 While rst=0: FSM -> IDLE; mem_req = 0, mem_we = 0, mem_be = 0; tag invalid; inbus = 0; codebus = 0; prefetch buffer invalid; stallX = 0.
REQ-022 Reset asserted mid-transaction SHALL abandon it, and the bridge SHALL ignore a late ack for that transaction.

Configuration
REQ-023 Macro RISC5_PREFETCH_EN: when defined, after each FETCH ack the bridge SHALL enter state PREFETCH and read word tag+1 into a one-entry buffer.
REQ-024 With RISC5_PREFETCH_EN, a fetch of tag+1 SHALL be served from the buffer with zero stall, and a data request arriving during PREFETCH SHALL stall until the prefetch ack.
REQ-025 With RISC5_PREFETCH_EN, a store hitting the buffer word SHALL invalidate the buffer.
REQ-026 Without RISC5_PREFETCH_EN, the PREFETCH state and buffer SHALL be absent, and behaviour SHALL be exactly REQ-007..020.

Structure
REQ-027 Shared package risc5_pkg SHALL hold the FSM state enum, IO_BASE default and mem_be encode constants.
REQ-028 SHALL be a single module with no sub-modules.

Verification
REQ-029 Reset, then fetch adr=24'hFFE000, ack after 3 cycles with 32'hE7000010: mem_addr=22'h3FF800, stallX high 4 cycles, codebus=32'hE7000010.
REQ-030 Repeat fetch of the same adr after REQ-029 -> no mem_req, stallX=0.
REQ-031 ben store adr=24'h000102, outbus=32'h000000AB -> mem_be=4'b0100, mem_we=1, mem_wdata=32'h000000AB.
REQ-032 Load adr=24'h000100, ack data 32'h12345678 -> inbus=32'h12345678 after ack; rd to adr=24'hFFFFC4 -> io_sel=1, mem_req=0, stallX=0.
REQ-033 Store to the fetch-tag word, then the same fetch -> tag invalidated, new FETCH issued.
REQ-034 Reset pulsed during FETCH with ack arriving after reset release -> codebus=0, FSM IDLE, late ack ignored.

Source files
------------

// File: rtl/risc5_pkg.sv
// Shared types and constants for the RISC5 memory bridge.
// RISC5_PREFETCH_EN adds the PREFETCH state used by the next-word prefetch buffer.
package risc5_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    STORE
`ifdef RISC5_PREFETCH_EN
    , PREFETCH
`endif
  } state_t;

  localparam logic [23:0] IO_BASE_DEF = 24'hFFFFC0;
  localparam logic [3:0]  BE_WORD     = 4'b1111;
  localparam logic [3:0]  BE_NONE     = 4'b0000;

  function automatic logic [3:0] be_onehot(input logic [1:0] a);
    return 4'b0001 << a;
  endfunction

endpackage

// File: rtl/risc5_mem_bridge.sv
// CPU-to-memory bridge: one-word fetch tag, serialized load/store/fetch requests.
// Optional next-word prefetch buffer enabled by defining RISC5_PREFETCH_EN.
module risc5_mem_bridge
  import risc5_pkg::*;
#(
  parameter logic [23:0] IO_BASE = IO_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] adr,
  input  logic        rd,
  input  logic        wr,
  input  logic        ben,
  input  logic [31:0] outbus,
  output logic [31:0] inbus,
  output logic [31:0] codebus,
  output logic        stallX,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [21:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        io_sel
);

  state_t      state, state_n;
  logic [21:0] wadr, tag;
  logic        tag_vld, tag_hit, dacc, fetch, we_q, stall_raw;
  logic [3:0]  be_q;
  logic [31:0] code_q;

  assign wadr    = adr[23:2];
  assign io_sel  = (adr[23:6] == IO_BASE[23:6]);
  assign dacc    = (rd | wr) & ~io_sel;
  assign fetch   = ~rd & ~wr;
  assign tag_hit = tag_vld & (tag == wadr);

`ifdef RISC5_PREFETCH_EN
  logic        pf_vld, pf_hit;
  logic [31:0] pf_buf;
  // The buffer always holds the word following the fetch tag.
  assign pf_hit  = pf_vld & tag_vld & (wadr == tag + 22'd1);
  assign codebus = (state == IDLE && fetch && !tag_hit && pf_hit) ? pf_buf : code_q;
`else
  assign codebus = code_q;
`endif

  always_comb begin
    state_n   = state;
    stall_raw = 1'b0;
    case (state)
      IDLE: begin
        if (dacc) state_n = wr ? STORE : LOAD;
        else if (fetch && !tag_hit) begin
`ifdef RISC5_PREFETCH_EN
          state_n = pf_hit ? PREFETCH : FETCH;
`else
          state_n = FETCH;
`endif
        end
        stall_raw = (state_n == FETCH) || (state_n == LOAD) || (state_n == STORE);
      end
      FETCH: begin
        stall_raw = 1'b1;
`ifdef RISC5_PREFETCH_EN
        if (mem_ack) state_n = PREFETCH;
`else
        if (mem_ack) state_n = IDLE;
`endif
      end
      LOAD, STORE: begin
        stall_raw = 1'b1;
        if (mem_ack) state_n = IDLE;
      end
`ifdef RISC5_PREFETCH_EN
      PREFETCH: begin
        // Only accesses that need the bus wait for the prefetch to land.
        stall_raw = dacc | (fetch & ~tag_hit);
        if (mem_ack) state_n = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // Reset gates the handshake outputs immediately, not just after the edge.
  assign stallX  = rst & stall_raw;
  assign mem_req = rst & (state != IDLE);
  assign mem_we  = rst & we_q;
  assign mem_be  = rst ? be_q : BE_NONE;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      we_q      <= 1'b0;
      be_q      <= BE_NONE;
      tag       <= '0;
      tag_vld   <= 1'b0;
      inbus     <= '0;
      code_q    <= '0;
`ifdef RISC5_PREFETCH_EN
      pf_vld    <= 1'b0;
      pf_buf    <= '0;
`endif
    end else begin
      state <= state_n;
      if (state == IDLE && state_n != IDLE) begin
        mem_addr  <= wadr;
        mem_wdata <= outbus;
        we_q      <= (state_n == STORE);
        be_q      <= (state_n == STORE && ben) ? be_onehot(adr[1:0]) : BE_WORD;
        if (state_n == STORE && tag == wadr) tag_vld <= 1'b0;
`ifdef RISC5_PREFETCH_EN
        if (state_n == STORE && wadr == tag + 22'd1) pf_vld <= 1'b0;
        if (state_n == PREFETCH) begin
          code_q   <= pf_buf;
          tag      <= wadr;
          pf_vld   <= 1'b0;
          mem_addr <= wadr + 22'd1;
        end
`endif
      end
      if (mem_ack) begin
        case (state)
          LOAD: inbus <= mem_rdata;
          FETCH: begin
            code_q  <= mem_rdata;
            tag     <= mem_addr;
            tag_vld <= 1'b1;
`ifdef RISC5_PREFETCH_EN
            mem_addr <= mem_addr + 22'd1;
            pf_vld   <= 1'b0;
`endif
          end
`ifdef RISC5_PREFETCH_EN
          PREFETCH: begin
            pf_buf <= mem_rdata;
            pf_vld <= 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_risc5_mem_bridge.sv
// Self-checking bench for risc5_mem_bridge: directed vector table, reset corner cases,
// and randomized operations scored against a one-entry fetch-tag reference model.
module tb_risc5_mem_bridge;

  logic        clk = 1'b0, rst = 1'b0;
  logic [23:0] adr;
  logic        rd, wr, ben, stallX, mem_req, mem_we, mem_ack, io_sel;
  logic [31:0] outbus, inbus, codebus, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [21:0] mem_addr;

  risc5_mem_bridge dut (
    .clk(clk), .rst(rst), .adr(adr), .rd(rd), .wr(wr), .ben(ben), .outbus(outbus),
    .inbus(inbus), .codebus(codebus), .stallX(stallX), .mem_req(mem_req),
    .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .io_sel(io_sel)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // Reference model: what the CPU should observe, per whole operation.
  logic        tag_v;
  logic [21:0] tag_m;
  logic [31:0] inbus_m, code_m;

  typedef struct {
    logic r, w, b;
    logic [23:0] a;
    logic [31:0] ob, rdat;
    int dly;
    logic ereq;
    logic [21:0] eaddr;
    logic [3:0] ebe;
    logic ewe;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic m_req(input logic r, input logic w, input logic [23:0] a);
    if (a[23:6] == 18'h3FFFF && (r || w)) return 1'b0;
    if (r || w) return 1'b1;
    return !(tag_v && tag_m == a[23:2]);
  endfunction

  task automatic m_reset();
    tag_v = 1'b0; tag_m = '0; inbus_m = '0; code_m = '0;
  endtask

  task automatic m_update(input logic r, input logic w, input logic [23:0] a,
                          input logic [31:0] rdat, input logic req);
    if (!req) return;
    if (w) begin
      if (tag_v && tag_m == a[23:2]) tag_v = 1'b0;
    end else if (r) inbus_m = rdat;
    else begin
      code_m = rdat; tag_m = a[23:2]; tag_v = 1'b1;
    end
  endtask

  task automatic park();
    rd = 1'b1; wr = 1'b0; ben = 1'b0; adr = 24'hFFFFC0; outbus = '0;
  endtask

  task automatic do_op(input string nm, input logic r, input logic w, input logic b,
                       input logic [23:0] a, input logic [31:0] ob, input logic [31:0] rdat,
                       input int dly, input logic ereq, input logic [21:0] eaddr,
                       input logic [3:0] ebe, input logic ewe);
    int scnt;
    logic mreq;
    mreq = m_req(r, w, a);
    @(negedge clk);
    rd = r; wr = w; ben = b; adr = a; outbus = ob;
    #1;
    chk({nm, ".io_sel"}, 32'(io_sel), 32'(a[23:6] == 18'h3FFFF));
    chk({nm, ".req0"}, 32'(mem_req), 32'd0);
    if (!ereq) begin
      chk({nm, ".nostall"}, 32'(stallX), 32'd0);
    end else begin
      scnt = int'(stallX);
      for (int k = 1; k <= dly; k++) begin
        @(negedge clk); #1;
        chk({nm, ".req"}, 32'(mem_req), 32'd1);
        chk({nm, ".addr"}, 32'(mem_addr), 32'(eaddr));
        chk({nm, ".be"}, 32'(mem_be), 32'(ebe));
        chk({nm, ".we"}, 32'(mem_we), 32'(ewe));
        if (ewe) chk({nm, ".wdata"}, mem_wdata, ob);
        scnt += int'(stallX);
        if (k == dly) begin mem_ack = 1'b1; mem_rdata = rdat; end
      end
    end
    m_update(r, w, a, rdat, mreq);
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = $urandom; park();
    #1;
    if (ereq) chk({nm, ".stallcnt"}, 32'(scnt), 32'(dly + 1));
    chk({nm, ".stall_after"}, 32'(stallX), 32'd0);
    chk({nm, ".req_after"}, 32'(mem_req), 32'd0);
    chk({nm, ".inbus"}, inbus, inbus_m);
    chk({nm, ".codebus"}, codebus, code_m);
  endtask

  initial begin
    logic [23:0] a;
    logic r, w, b;
    int kind;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 24'hFFE000, 32'h0, 32'hE7000010, 3, 1'b1, 22'h3FF800, 4'hF, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 24'hFFE000, 32'h0, 32'h0,        1, 1'b0, 22'h0,      4'h0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 24'h000102, 32'hAB, 32'h0,       1, 1'b1, 22'h000040, 4'b0100, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 24'h000100, 32'h0, 32'h12345678, 2, 1'b1, 22'h000040, 4'hF, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 24'hFFFFC4, 32'h0, 32'h0,        1, 1'b0, 22'h0,      4'h0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 24'hFFE000, 32'h5, 32'h0,        2, 1'b1, 22'h3FF800, 4'hF, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 24'hFFE000, 32'h0, 32'h00000011, 1, 1'b1, 22'h3FF800, 4'hF, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 24'hFFE002, 32'h0, 32'h0,        1, 1'b0, 22'h0,      4'h0, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 24'h000003, 32'hCD, 32'h0,       1, 1'b1, 22'h000000, 4'b1000, 1'b1};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 24'hFFFFFC, 32'h9, 32'h0,        1, 1'b0, 22'h0,      4'h0, 1'b0};

    // Reset held with a fetch pattern on the inputs: everything must stay quiet.
    rd = 1'b0; wr = 1'b0; ben = 1'b0; adr = 24'h0; outbus = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst.stallX", 32'(stallX), 32'd0);
    chk("rst.req", 32'(mem_req), 32'd0);
    chk("rst.we", 32'(mem_we), 32'd0);
    chk("rst.be", 32'(mem_be), 32'd0);
    chk("rst.inbus", inbus, 32'd0);
    chk("rst.codebus", codebus, 32'd0);
    park();
    rst = 1'b1;

    for (int i = 0; i < 10; i++)
      do_op($sformatf("vec%0d", i), vecs[i].r, vecs[i].w, vecs[i].b, vecs[i].a, vecs[i].ob,
            vecs[i].rdat, vecs[i].dly, vecs[i].ereq, vecs[i].eaddr, vecs[i].ebe, vecs[i].ewe);

    // Reset mid-fetch, then a late ack that must be ignored.
    @(negedge clk);
    rd = 1'b0; wr = 1'b0; adr = 24'h000200;
    @(negedge clk); #1;
    chk("midrst.req_before", 32'(mem_req), 32'd1);
    rst = 1'b0; park();
    @(negedge clk); #1;
    chk("midrst.req_in_rst", 32'(mem_req), 32'd0);
    chk("midrst.stall_in_rst", 32'(stallX), 32'd0);
    rst = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mem_ack = 1'b0; #1;
    chk("midrst.codebus", codebus, 32'd0);
    chk("midrst.inbus", inbus, 32'd0);
    chk("midrst.req_late", 32'(mem_req), 32'd0);
    chk("midrst.stall_late", 32'(stallX), 32'd0);
    m_reset();
    do_op("midrst.refetch", 1'b0, 1'b0, 1'b0, 24'h000200, 32'h0, 32'hA5A5A5A5, 2,
          m_req(1'b0, 1'b0, 24'h000200), 22'h000080, 4'hF, 1'b0);

    // Randomized mix against the reference model.
    for (int i = 0; i < 200; i++) begin
      kind = int'($urandom_range(0, 3));
      b = 1'b0;
      if (kind == 0) begin
        r = 1'b0; w = 1'b0;
        a = 24'hFFE000 + 24'($urandom_range(0, 3)) * 24'd4 + 24'($urandom_range(0, 3));
      end else if (kind == 3) begin
        r = $urandom_range(0, 1) == 1; w = !r;
        a = 24'hFFFFC0 + 24'($urandom_range(0, 63));
      end else begin
        r = (kind == 1); w = (kind == 2); b = $urandom_range(0, 1) == 1;
        a = ($urandom_range(0, 1) == 1)
            ? 24'hFFE000 + 24'($urandom_range(0, 15))
            : 24'h000100 + 24'($urandom_range(0, 255));
      end
      do_op($sformatf("rnd%0d", i), r, w, b, a, $urandom, $urandom, int'($urandom_range(1, 4)),
            m_req(r, w, a), a[23:2], (w && b) ? 4'(4'b0001 << a[1:0]) : 4'hF, w);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
